hc_lead: RTL and testbench

- Parametrised N-channel hysteresis leader tracker; successor to the two-channel hysteresis comparator.
- Watches N W-bit timestamp/magnitude channels and reports which channel is the current leader.
- Leadership changes only when a challenger beats the leader by more than a runtime threshold for DWELL consecutive cycles.
- Feeds downstream selection/muxing logic that must not chatter between near-equal channels.

---
 rtl/hc_lead_if.sv | 25 ++
 rtl/hc_lead.sv | 159 +++++++++++++++
 tb/tb_hc_lead.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/hc_lead_if.sv
// Bundle of channel inputs and leader-status outputs for the hc_lead tracker.
// The master side drives channel values and threshold; the slave side reports the leader.
interface hc_lead_if #(
   parameter int N = 4,
   parameter int W = 8
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [N*W-1:0] ts;
   logic [W-1:0]   th;
   logic [IW-1:0]  leader_idx;
   logic           leader_vld;
   logic           switch;
   logic           pending;

   modport master (
      output ts, th,
      input  leader_idx, leader_vld, switch, pending
   );

   modport slave (
      input  ts, th,
      output leader_idx, leader_vld, switch, pending
   );
endinterface

// File: rtl/hc_lead.sv
// N-channel hysteresis leader tracker: a challenger must beat the leader by more than th
// for DWELL consecutive cycles. Optional freeze input enabled by macro HC_HOLD_EN.
module hc_lead #(
   parameter int N     = 4,
   parameter int W     = 8,
   parameter int DWELL = 2
) (
   input logic clk,
   input logic rst,
`ifdef HC_HOLD_EN
   input logic hold,
`endif
   hc_lead_if.slave bus
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(DWELL + 1);

   typedef enum logic [1:0] {IDLE, LEAD, CHAL} state_t;

   state_t        state_reg, state_next;
   logic [IW-1:0] leader_idx_reg, leader_idx_next;
   logic [IW-1:0] chal_idx_reg, chal_idx_next;
   logic          leader_vld_reg, leader_vld_next;
   logic          switch_reg, switch_next;
   logic [CW-1:0] count_reg, count_next;

   logic [W-1:0]  vals [N];
   logic [W-1:0]  lead_val;
   logic          lead_act;
   logic          cand_found;
   logic [IW-1:0] cand_idx;
   logic [W-1:0]  cand_val;
   logic          challenge;
   logic          hold_act;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_split
         assign vals[gi] = bus.ts[gi*W +: W];
      end
   endgenerate

`ifdef HC_HOLD_EN
   assign hold_act = hold;
`else
   assign hold_act = 1'b0;
`endif

   assign lead_val = vals[leader_idx_reg];
   assign lead_act = (lead_val != '0);

   // Strictly-greater scan keeps the lowest index on ties.
   always_comb begin
      cand_found = 1'b0;
      cand_idx   = '0;
      cand_val   = '0;
      for (int i = 0; i < N; i++) begin
         if ((vals[i] != '0) &&
             ((state_reg == IDLE) || (IW'(i) != leader_idx_reg)) &&
             (!cand_found || (vals[i] > cand_val))) begin
            cand_found = 1'b1;
            cand_idx   = IW'(i);
            cand_val   = vals[i];
         end
      end
   end

   assign challenge = cand_found &&
                      ({1'b0, cand_val} > ({1'b0, lead_val} + {1'b0, bus.th}));

   always_comb begin
      state_next      = state_reg;
      leader_idx_next = leader_idx_reg;
      leader_vld_next = leader_vld_reg;
      chal_idx_next   = chal_idx_reg;
      count_next      = count_reg;
      switch_next     = 1'b0;
      if (!hold_act) begin
         case (state_reg)
            IDLE: begin
               if (cand_found) begin
                  leader_idx_next = cand_idx;
                  leader_vld_next = 1'b1;
                  switch_next     = 1'b1;
                  count_next      = '0;
                  state_next      = LEAD;
               end
            end
            LEAD, CHAL: begin
               if (!lead_act) begin
                  // Losing the leader overrides any challenge in flight.
                  count_next = '0;
                  if (cand_found) begin
                     leader_idx_next = cand_idx;
                     switch_next     = 1'b1;
                     state_next      = LEAD;
                  end else begin
                     leader_vld_next = 1'b0;
                     state_next      = IDLE;
                  end
               end else if (challenge) begin
                  if (state_reg == LEAD) begin
                     if (DWELL == 1) begin
                        leader_idx_next = cand_idx;
                        switch_next     = 1'b1;
                        count_next      = '0;
                     end else begin
                        chal_idx_next = cand_idx;
                        count_next    = CW'(1);
                        state_next    = CHAL;
                     end
                  end else if (cand_idx == chal_idx_reg) begin
                     if (count_reg == CW'(DWELL - 1)) begin
                        leader_idx_next = chal_idx_reg;
                        switch_next     = 1'b1;
                        count_next      = '0;
                        state_next      = LEAD;
                     end else begin
                        count_next = count_reg + CW'(1);
                     end
                  end else begin
                     chal_idx_next = cand_idx;
                     count_next    = CW'(1);
                  end
               end else begin
                  count_next = '0;
                  state_next = LEAD;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         leader_idx_reg <= '0;
         leader_vld_reg <= 1'b0;
         switch_reg     <= 1'b0;
         chal_idx_reg   <= '0;
         count_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         leader_idx_reg <= leader_idx_next;
         leader_vld_reg <= leader_vld_next;
         switch_reg     <= switch_next;
         chal_idx_reg   <= chal_idx_next;
         count_reg      <= count_next;
      end
   end

   assign bus.leader_idx = leader_idx_reg;
   assign bus.leader_vld = leader_vld_reg;
   assign bus.switch     = switch_reg;
   assign bus.pending    = (state_reg == CHAL);
endmodule

// File: tb/tb_hc_lead.sv
// Bench for hc_lead: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a streak-counting reference model.
module tb_hc_lead;
   localparam int N     = 4;
   localparam int W     = 8;
   localparam int DWELL = 2;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic hold = 1'b0;

   always #5 clk = ~clk;

   hc_lead_if #(.N(N), .W(W)) bus ();

   hc_lead #(.N(N), .W(W), .DWELL(DWELL)) dut (
      .clk  (clk),
      .rst  (rst),
`ifdef HC_HOLD_EN
      .hold (hold),
`endif
      .bus  (bus)
   );

   int total = 0;
   int bad   = 0;

   // Model: leader, valid flag, and the current run of consecutive qualifying cycles.
   int m_leader = 0;
   bit m_vld    = 0;
   bit m_sw     = 0;
   int s_idx    = 0;
   int s_len    = 0;

   function automatic int pick(input int v[N], input int excl);
      int best = -1;
      for (int i = 0; i < N; i++)
         if (v[i] != 0 && i != excl && (best < 0 || v[i] > v[best])) best = i;
      return best;
   endfunction

   always @(posedge clk) begin
      int v[N];
      int c;
      for (int i = 0; i < N; i++) v[i] = int'(bus.ts[i*W +: W]);
      m_sw = 0;
      if (rst) begin
         m_leader = 0; m_vld = 0; s_idx = 0; s_len = 0;
      end else if (hold) begin
         // frozen
      end else if (!m_vld) begin
         c = pick(v, -1);
         if (c >= 0) begin m_leader = c; m_vld = 1; m_sw = 1; end
         s_len = 0;
      end else if (v[m_leader] == 0) begin
         c = pick(v, m_leader);
         if (c >= 0) begin m_leader = c; m_sw = 1; end
         else m_vld = 0;
         s_len = 0;
      end else begin
         c = pick(v, m_leader);
         if (c >= 0 && v[c] > v[m_leader] + int'(bus.th)) begin
            if (s_len > 0 && s_idx == c) s_len++;
            else begin s_idx = c; s_len = 1; end
            if (s_len >= DWELL) begin m_leader = c; m_sw = 1; s_len = 0; end
         end else begin
            s_len = 0;
         end
      end
   end

   always @(negedge clk) begin
      total += 4;
      if (int'(bus.leader_idx) != m_leader) begin
         bad++;
         $display("FAIL model_leader_idx t=%0t got=%0d exp=%0d", $time, bus.leader_idx, m_leader);
      end
      if (bus.leader_vld !== m_vld) begin
         bad++;
         $display("FAIL model_leader_vld t=%0t got=%0b exp=%0b", $time, bus.leader_vld, m_vld);
      end
      if (bus.switch !== m_sw) begin
         bad++;
         $display("FAIL model_switch t=%0t got=%0b exp=%0b", $time, bus.switch, m_sw);
      end
      if (bus.pending !== (s_len > 0)) begin
         bad++;
         $display("FAIL model_pending t=%0t got=%0b exp=%0b", $time, bus.pending, (s_len > 0));
      end
   end

   task automatic chk(input string nm, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, got, exp);
      end
   endtask

   task automatic step(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
      bus.ts = {d, c, b, a};
      @(negedge clk);
      $display("cyc rst=%0b hold=%0b ts=%0d,%0d,%0d,%0d th=%0d -> idx=%0d vld=%0b sw=%0b pend=%0b",
               rst, hold, a, b, c, d, bus.th, bus.leader_idx, bus.leader_vld,
               bus.switch, bus.pending);
   endtask

   initial begin
      logic [7:0] rv [N];
      bus.ts = '0;
      bus.th = 8'd5;
      rst    = 1'b1;

      repeat (5) begin
         step(0, 0, 0, 0);
         chk("rst_vld", int'(bus.leader_vld), 0);
         chk("rst_sw", int'(bus.switch), 0);
         chk("rst_pend", int'(bus.pending), 0);
      end
      rst = 1'b0;

      step(10, 0, 0, 0);
      chk("acq_idx", int'(bus.leader_idx), 0);
      chk("acq_vld", int'(bus.leader_vld), 1);
      chk("acq_sw", int'(bus.switch), 1);
      step(10, 0, 0, 0);
      chk("acq_sw_once", int'(bus.switch), 0);

      step(10, 0, 15, 0);
      chk("eq_th_pend", int'(bus.pending), 0);
      chk("eq_th_idx", int'(bus.leader_idx), 0);
      step(10, 0, 16, 0);
      chk("chal_pend", int'(bus.pending), 1);
      chk("chal_idx_hold", int'(bus.leader_idx), 0);
      step(10, 0, 16, 0);
      chk("dwell_idx", int'(bus.leader_idx), 2);
      chk("dwell_sw", int'(bus.switch), 1);
      chk("dwell_pend", int'(bus.pending), 0);

      rst = 1'b1; step(0, 0, 0, 0); rst = 1'b0;
      step(10, 0, 0, 0);
      step(10, 0, 16, 0);
      chk("abort_pend1", int'(bus.pending), 1);
      step(10, 0, 14, 0);
      chk("abort_pend0", int'(bus.pending), 0);
      chk("abort_sw", int'(bus.switch), 0);
      chk("abort_idx", int'(bus.leader_idx), 0);
      step(10, 20, 20, 0);
      chk("tie_pend", int'(bus.pending), 1);
      step(10, 20, 20, 0);
      chk("tie_idx", int'(bus.leader_idx), 1);
      chk("tie_sw", int'(bus.switch), 1);

      rst = 1'b1; step(0, 0, 0, 0); rst = 1'b0;
      step(10, 0, 0, 0);
      step(0, 3, 0, 3);
      chk("loss_idx", int'(bus.leader_idx), 1);
      chk("loss_sw", int'(bus.switch), 1);
      step(0, 0, 0, 0);
      chk("idle_vld", int'(bus.leader_vld), 0);
      chk("idle_idx", int'(bus.leader_idx), 1);
      chk("idle_sw", int'(bus.switch), 0);

      rst = 1'b1; step(0, 0, 0, 0); rst = 1'b0;
      step(10, 0, 0, 0);
      step(10, 20, 0, 0);
      chk("midrst_pend1", int'(bus.pending), 1);
      rst = 1'b1; step(10, 20, 0, 0);
      chk("midrst_pend0", int'(bus.pending), 0);
      chk("midrst_vld", int'(bus.leader_vld), 0);
      chk("midrst_idx", int'(bus.leader_idx), 0);
      rst = 1'b0;

      bus.th = 8'd10;
      step(250, 0, 0, 0);
      chk("wrap_acq_sw", int'(bus.switch), 1);
      step(250, 255, 0, 0);
      chk("wrap_pend", int'(bus.pending), 0);
      chk("wrap_sw", int'(bus.switch), 0);
      step(250, 255, 0, 0);
      chk("wrap_idx", int'(bus.leader_idx), 0);

`ifdef HC_HOLD_EN
      hold = 1'b1;
      step(0, 255, 0, 0);
      chk("hold_idx", int'(bus.leader_idx), 0);
      chk("hold_vld", int'(bus.leader_vld), 1);
      chk("hold_sw", int'(bus.switch), 0);
      step(0, 255, 0, 0);
      chk("hold_idx2", int'(bus.leader_idx), 0);
      hold = 1'b0;
      step(0, 255, 0, 0);
      chk("release_idx", int'(bus.leader_idx), 1);
      chk("release_sw", int'(bus.switch), 1);
`endif

      bus.th = 8'd5;
      for (int i = 0; i < N; i++) rv[i] = 8'($urandom_range(1, 30));
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               int r = int'($urandom_range(0, 9));
               if (r < 3)       rv[i] = 8'd0;
               else if (r == 9) rv[i] = 8'($urandom_range(240, 255));
               else             rv[i] = 8'($urandom_range(1, 40));
            end
         end
         if ($urandom_range(0, 15) == 0)
            bus.th = ($urandom_range(0, 20) == 0) ? 8'($urandom_range(240, 255))
                                                  : 8'($urandom_range(0, 12));
         rst = ($urandom_range(0, 199) == 0);
`ifdef HC_HOLD_EN
         hold = ($urandom_range(0, 7) == 0);
`endif
         step(rv[0], rv[1], rv[2], rv[3]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
